// File: rtl/vga_pkg.sv
// Shared timing defaults and elaboration helpers for the VGA raster engine.
package vga_pkg;

    // 640x480@60 timing, pixel clock 25.175 MHz
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Line or frame length from the four region sizes of one axis.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that lines timing flags up with framebuffer data.
module vga_delay_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; reset empties the whole line.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan.sv
// Parametrised VGA raster engine: counters, downscaled framebuffer addressing,
// and a single aligned output register for sync, enable and colour.
module vga_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 3,
    parameter int COL_W       = 7,
    parameter int ROW_W       = 6,
    parameter int RD_LAT      = 1,
    parameter int CW          = 4
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [3*CW-1:0]   din,
    output logic [COL_W-1:0]  col_addr,
    output logic [ROW_W-1:0]  row_addr,
    output logic              rd_en,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 4) begin : g_bad_scale
        $error("vga_scan: SCALE_SHIFT must be within 0..4");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("vga_scan: RD_LAT must be within 1..4");
    end
    if ((H_ACTIVE >> SCALE_SHIFT) > (1 << COL_W)) begin : g_bad_col_w
        $error("vga_scan: COL_W too narrow for H_ACTIVE>>SCALE_SHIFT");
    end
    if ((V_ACTIVE >> SCALE_SHIFT) > (1 << ROW_W)) begin : g_bad_row_w
        $error("vga_scan: ROW_W too narrow for V_ACTIVE>>SCALE_SHIFT");
    end

    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic            act, hs_raw, vs_raw, fs_raw, ls_raw;
    logic [4:0]      dly_q;
    logic            act_dl, hs_dl, vs_dl, fs_dl, ls_dl;
    logic            de_q, hs_q, vs_q, fs_q, ls_q;
    logic            de_d, hs_d, vs_d, fs_d, ls_d;
    logic [3*CW-1:0] rgb_q, rgb_d;

    // Raster position advance: wrap h at line end, step v, wrap v at frame end.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Raster position counters.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 0: region decode straight off the counter flops
    assign act    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hs_raw = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vs_raw = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    assign fs_raw = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign ls_raw = (h_cnt_q == '0) && (v_cnt_q < V_ACT_C);

    // Addresses go out unregistered so the RAM latency is the only delay.
    assign rd_en    = act;
    assign col_addr = act ? COL_W'(h_cnt_q >> SCALE_SHIFT) : '0;
    assign row_addr = act ? ROW_W'(v_cnt_q >> SCALE_SHIFT) : '0;

    // Stages 1..RD_LAT: timing flags wait for the framebuffer read
    vga_delay_line #(
        .WIDTH (5),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk_i (vga_clk),
        .rst   (rst),
        .d_i   ({act, hs_raw, vs_raw, fs_raw, ls_raw}),
        .q_o   (dly_q)
    );

    assign {act_dl, hs_dl, vs_dl, fs_dl, ls_dl} = dly_q;

    // Final-stage values: apply sync polarity and blank colour outside the active area.
    always_comb begin
        de_d  = act_dl;
        hs_d  = hs_dl ? HS_POL : ~HS_POL;
        vs_d  = vs_dl ? VS_POL : ~VS_POL;
        rgb_d = act_dl ? din : '0;
        fs_d  = fs_dl;
        ls_d  = ls_dl;
    end

    // Output register: every pin toggles on the same edge, so nothing skews.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
        end
    end

    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign r           = rgb_q[3*CW-1:2*CW];
    assign g           = rgb_q[2*CW-1:CW];
    assign b           = rgb_q[CW-1:0];
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: small-raster instance checked cycle by cycle through a
// scoreboard, plus a default-parameter instance checked on line statistics.
module tb_vga_scan;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] din = 12'h000;
    logic [1:0]  col_addr;
    logic        row_addr;
    logic        rd_en, hs, vs, de, fs, ls;
    logic [3:0]  r, g, b;

    logic [11:0] d_din = 12'h5A5;
    logic [6:0]  d_col_addr;
    logic [5:0]  d_row_addr;
    logic        d_rd_en, d_hs, d_vs, d_de, d_fs, d_ls;
    logic [3:0]  d_r, d_g, d_b;

    exp_t        exp_q[$];
    logic [11:0] ram_q[$];

    int total = 0;
    int bad   = 0;
    int mh, mv, cyc;
    int fs_seen, last_fs, period, ls_since, ls_per_frame, first_de;
    int d_de_cnt = 0;
    int d_hsl_cnt = 0;
    bit dcount_on = 1'b0;

    always #5 clk = ~clk;

    vga_scan #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_SHIFT(1),
        .COL_W(2), .ROW_W(1), .RD_LAT(2), .CW(4)
    ) dut (
        .vga_clk(clk), .rst(rst), .din(din),
        .col_addr(col_addr), .row_addr(row_addr), .rd_en(rd_en),
        .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
        .frame_start(fs), .line_start(ls)
    );

    vga_scan u_def (
        .vga_clk(clk), .rst(rst), .din(d_din),
        .col_addr(d_col_addr), .row_addr(d_row_addr), .rd_en(d_rd_en),
        .hs(d_hs), .vs(d_vs), .de(d_de), .r(d_r), .g(d_g), .b(d_b),
        .frame_start(d_fs), .line_start(d_ls)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic exp_t idle_out();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Expected pins for raster position (h,v) of the 14x7 test raster.
    function automatic exp_t model_out(input int h, input int v);
        exp_t e;
        e.de  = (h < 8) && (v < 4);
        e.hs  = (h >= 10 && h <= 11) ? 1'b0 : 1'b1;
        e.vs  = (v == 5) ? 1'b0 : 1'b1;
        e.fs  = (h == 0) && (v == 0);
        e.ls  = (h == 0) && (v < 4);
        e.rgb = e.de ? 12'(((v >> 1) << 2) | (h >> 1)) : 12'h000;
        return e;
    endfunction

    task automatic restart_model();
        mh = 0; mv = 0; cyc = 0;
        fs_seen = 0; last_fs = 0; period = -1; ls_since = 0; ls_per_frame = -1; first_de = -1;
        exp_q.delete();
        repeat (3) exp_q.push_back(idle_out());
        ram_q.delete();
        repeat (2) ram_q.push_back(12'hFFF);
    endtask

    // One pixel clock: check addresses, feed the RAM model, score outputs, advance.
    task automatic step();
        bit   act;
        exp_t e;
        act = (mh < 8) && (mv < 4);
        check_val("rd_en", 32'(rd_en), 32'(act));
        check_val("col_addr", 32'(col_addr), act ? 32'(mh >> 1) : 32'd0);
        check_val("row_addr", 32'(row_addr), act ? 32'(mv >> 1) : 32'd0);
        ram_q.push_back(act ? 12'(((mv >> 1) << 2) | (mh >> 1)) : 12'hFFF);
        din = ram_q.pop_front();
        exp_q.push_back(model_out(mh, mv));
        e = exp_q.pop_front();
        check_val("de", 32'(de), 32'(e.de));
        check_val("hs", 32'(hs), 32'(e.hs));
        check_val("vs", 32'(vs), 32'(e.vs));
        check_val("frame_start", 32'(fs), 32'(e.fs));
        check_val("line_start", 32'(ls), 32'(e.ls));
        check_val("rgb", 32'({r, g, b}), 32'(e.rgb));
        if (fs === 1'b1) begin
            if (fs_seen == 1) begin
                period = cyc - last_fs;
                ls_per_frame = ls_since;
            end
            last_fs = cyc;
            ls_since = 0;
            fs_seen++;
        end
        if (ls === 1'b1) ls_since++;
        if (de === 1'b1 && first_de < 0) first_de = cyc;
        if (dcount_on) begin
            if (d_de === 1'b1) d_de_cnt++;
            if (d_hs === 1'b0) d_hsl_cnt++;
        end
        mh++;
        if (mh == 14) begin
            mh = 0;
            mv++;
            if (mv == 7) mv = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_pins(input string pfx);
        check_val({pfx, "_hs"}, 32'(hs), 32'd1);
        check_val({pfx, "_vs"}, 32'(vs), 32'd1);
        check_val({pfx, "_de"}, 32'(de), 32'd0);
        check_val({pfx, "_rgb"}, 32'({r, g, b}), 32'd0);
        check_val({pfx, "_fs"}, 32'(fs), 32'd0);
        check_val({pfx, "_ls"}, 32'(ls), 32'd0);
        check_val({pfx, "_col"}, 32'(col_addr), 32'd0);
        check_val({pfx, "_row"}, 32'(row_addr), 32'd0);
        check_val({pfx, "_rd_en"}, 32'(rd_en), 32'd1);
        check_val({pfx, "_def_hs"}, 32'(d_hs), 32'd1);
        check_val({pfx, "_def_de"}, 32'(d_de), 32'd0);
    endtask

    initial begin
        cyc = 0;
        #2 rst = 1'b1;
        #2 check_reset_pins("rst");

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        restart_model();
        dcount_on = 1'b1;
        repeat (1600) step();
        dcount_on = 1'b0;
        check_val("first_de", 32'(first_de), 32'd3);
        check_val("frame_period", 32'(period), 32'd98);
        check_val("ls_per_frame", 32'(ls_per_frame), 32'd4);
        check_val("def_de_cycles", 32'(d_de_cnt), 32'd1280);
        check_val("def_hs_low", 32'(d_hsl_cnt), 32'd192);

        while (!(mh == 5 && mv == 2)) step();
        #1 rst = 1'b1;
        #1 check_reset_pins("mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        restart_model();
        repeat (300) step();
        check_val("re_first_de", 32'(first_de), 32'd3);
        check_val("re_frame_period", 32'(period), 32'd98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scan.md
# vga_scan

Parametrised VGA raster engine, the successor to the fixed 640x480 `vga` controller. It generates horizontal and vertical timing from parameters and issues framebuffer read addresses at a power-of-two downscale. It absorbs a configurable framebuffer read latency and drives sync and colour outputs from one aligned register stage. It sits between the pixel framebuffer RAM and the board VGA DAC pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
- `HS_POL` / `VS_POL`, 0 / 0: asserted level of `hs` / `vs` (0 = active-low).
- `SCALE_SHIFT`, 3: log2 of the downscale factor (0..4).
- `COL_W` / `ROW_W`, 7 / 6: address widths. Must satisfy `H_ACTIVE>>SCALE_SHIFT <= 2^COL_W` and `V_ACTIVE>>SCALE_SHIFT <= 2^ROW_W`.
- `RD_LAT`, 1: framebuffer read latency in cycles (1..4).
- `CW`, 4: bits per colour channel.

Ports:
- `vga_clk`  in  1  pixel clock. The only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  3*CW  framebuffer pixel data, packed {r,g,b}. Valid `RD_LAT` cycles after its address.
- `col_addr`  out  COL_W  framebuffer column address.
- `row_addr`  out  ROW_W  framebuffer row address.
- `rd_en`  out  1  address valid (active region).
- `hs`  out  1  horizontal sync.
- `vs`  out  1  vertical sync.
- `de`  out  1  output pixel is visible.
- `r`, `g`, `b`  out  CW each  colour outputs.
- `frame_start`  out  1  one-cycle pulse aligned with output pixel (0,0).
- `line_start`  out  1  one-cycle pulse aligned with output pixel 0 of each active line.

## Operation
- Totals: `H_TOTAL` = sum of the four H parameters (800); `V_TOTAL` = sum of the four V parameters (525).
- Counters:
  - `h_cnt` counts 0..H_TOTAL-1, then wraps to 0 and advances `v_cnt`.
  - `v_cnt` counts 0..V_TOTAL-1, then wraps to 0.
  - Counter width is clog2 of the total.
- Region order per axis: active, front porch, sync, back porch.
- Stage-0 decode, from the counter flops:
  - `act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`.
  - `hs_raw` is true for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`. `vs_raw` is the same on the V axis.
- Addressing:
  - `rd_en = act`.
  - `col_addr = act ? h_cnt>>SCALE_SHIFT : 0` and `row_addr = act ? v_cnt>>SCALE_SHIFT : 0`, both truncated to their widths.
  - These outputs are direct decodes of the counter flops, with no extra register.
- Alignment: `act`, `hs_raw`, `vs_raw`, and the first-pixel flags (h=0,v=0) and (h=0,v<V_ACTIVE) pass through an `RD_LAT`-deep delay line. A final register then produces:
  - `de`;
  - `hs = hs_d ? HS_POL : ~HS_POL` (`vs` likewise);
  - `{r,g,b} = de_d ? din : 0`;
  - `frame_start` and `line_start`.
- Blanking: colour outputs are 0 whenever `de`=0, whatever `din` holds.

## Timing
- Output latency is `RD_LAT+1` cycles. Outputs for counter state (h,v) appear `RD_LAT+1` edges after the counters hold (h,v).
- All outputs on the final register change together. `hs`, `vs`, `de` and colour are never skewed relative to each other.
- Reset (asynchronous):
  - Counters go to 0 and the delay line clears.
  - `hs`=~HS_POL, `vs`=~VS_POL; `de`, `r`, `g`, `b`, `frame_start` and `line_start` all go to 0.
  - `col_addr` and `row_addr` = 0 and `rd_en` = 1, since (0,0) is active.
- Reset mid-frame: outputs take their reset values immediately, with no clock needed. After release, counting restarts at (0,0). The first `de`=1 and `frame_start` appear `RD_LAT+1` cycles after the first rising edge.
- Wrap: at h=H_TOTAL-1, v=V_TOTAL-1 the next state is (0,0). `vs` stays continuous across the wrap, with no glitch cycle.
- Defaults: `hs` is asserted for h 656..751; `vs` is asserted for v 490..491; one frame is 420000 cycles.

## Structure
- `vga_pkg` holds:
  - the default 640x480@60 timing constants;
  - a `clog2` function;
  - a localparam helper for `H_TOTAL` / `V_TOTAL`.
- One sub-module, `vga_delay_line`, with parameters `WIDTH` and `DEPTH`: a shift register reset by `rst`. It is instantiated once for the {act, hs, vs, fs, ls} bundle.
- Elaboration-time check: flag an error if `SCALE_SHIFT` or `RD_LAT` is outside its range, or if an address width is too narrow.

## Test plan
All scenarios except the last use small parameters: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), `SCALE_SHIFT`=1, `RD_LAT`=2, model RAM with `din` = {row, col}.
- Reset, release, count edges:
  - `hs` is asserted for exactly h=10..11 of every line;
  - `vs` is asserted for lines 5;
  - the period is 98 cycles.
- Address sweep: on line 0, `col_addr` reads 0,0,1,1,2,2,3,3 and then 0 with `rd_en`=0 for 6 cycles. `row_addr` reads 0,0,1,1 across the active lines.
- Latency: colour equals model data for (h,v) exactly 3 edges after counters=(h,v). Colour is 0 whenever `de`=0, including when `din`=12'hFFF.
- Pulses: `frame_start` fires once per 98 cycles, coincident with the first `de`. `line_start` fires 4 times per frame.
- Mid-frame async reset at v=2,h=5: outputs take their reset values within the same cycle. After release the frame restarts cleanly, with the first `de` after 3 edges.
- Default parameters: one full frame shows 420000 cycles, 307200 `de` cycles, and `hs` low 96 cycles per line.
